integration_scheduler: RTL and testbench

- Sequences the correlator datapath through repeated integration frames: clear counters, integrate N sample clocks, request packet capture, wait for the packet generator's done handshake.
- Between frames, optionally sweeps per-line auto and cross lag offsets for lag-scan mode.
- Sits between CMD_PARSER (configuration) and the counter/delay-line array and TX_WORD (capture).

---
 rtl/xc_sched_pkg.sv | 19 +
 rtl/lag_stepper.sv | 48 ++++
 rtl/integration_scheduler.sv | 179 +++++++++++++++++
 tb/tb_integration_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_sched_pkg.sv
// Shared types and default constants for the correlator integration scheduler.
package xc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        INTEGRATE,
        CAPTURE,
        WAIT_ACK,
        STEP
    } sched_state_e;

    localparam int unsigned LAG_WIDTH   = 12;
    localparam int unsigned FRAME_WIDTH = 16;

    // WAIT_ACK cycles tolerated before the watchdog forces STEP.
    localparam logic [15:0] ACK_TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/lag_stepper.sv
// Single lag offset register: follows base on load, advances or reloads on step.
module lag_stepper
    import xc_sched_pkg::*;
#(
    parameter int unsigned LAG_WIDTH = xc_sched_pkg::LAG_WIDTH,
    parameter int unsigned LIMIT     = 1
) (
    input  logic                 smpclk,
    input  logic                 reset_n,
    input  logic [LAG_WIDTH-1:0] base,
    input  logic                 scan,
    input  logic                 step,
    input  logic                 load,
    output logic [LAG_WIDTH-1:0] lag
);

    localparam logic [LAG_WIDTH:0] LIMIT_W = (LAG_WIDTH + 1)'(LIMIT);

    logic [LAG_WIDTH-1:0] lag_q, lag_d;
    logic [LAG_WIDTH:0]   lag_inc;

    // One extra bit so an increment past the top of the range still wraps to base.
    assign lag_inc = {1'b0, lag_q} + {{LAG_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        lag_d = lag_q;
        if (load) begin
            lag_d = base;
        end else if (step) begin
            if (scan && (lag_inc < LIMIT_W)) begin
                lag_d = lag_inc[LAG_WIDTH-1:0];
            end else begin
                lag_d = base;
            end
        end
    end

    always_ff @(posedge smpclk or negedge reset_n) begin
        if (!reset_n) begin
            lag_q <= '0;
        end else begin
            lag_q <= lag_d;
        end
    end

    assign lag = lag_q;

endmodule

// File: rtl/integration_scheduler.sv
// Frame sequencer: clear, integrate, capture, wait for ack, step lags.
// Optional ack watchdog and ack_timeout port: INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN.
module integration_scheduler
    import xc_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS    = 8,
    parameter int unsigned LAG_WIDTH     = xc_sched_pkg::LAG_WIDTH,
    parameter int unsigned MAX_LAG_AUTO  = 1,
    parameter int unsigned MAX_LAG_CROSS = 1,
    parameter int unsigned INT_WIDTH     = 32,
    parameter int unsigned FRAME_WIDTH   = xc_sched_pkg::FRAME_WIDTH
) (
    input  logic                            smpclk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            integrate,
    input  logic                            strobe,
    input  logic [INT_WIDTH-1:0]            int_cycles,
    input  logic [NUM_INPUTS-1:0]           scan_auto,
    input  logic [NUM_INPUTS-1:0]           scan_cross,
    input  logic [NUM_INPUTS*LAG_WIDTH-1:0] auto_base,
    input  logic [NUM_INPUTS*LAG_WIDTH-1:0] cross_base,
    input  logic                            capture_ack,
    output logic                            counters_reset,
    output logic                            capture,
    output logic [NUM_INPUTS*LAG_WIDTH-1:0] auto_lag,
    output logic [NUM_INPUTS*LAG_WIDTH-1:0] cross_lag,
    output logic                            busy,
`ifdef INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN
    output logic                            ack_timeout,
`endif
    output logic [FRAME_WIDTH-1:0]          frame_count
);

    sched_state_e            state_q, state_d;
    logic [INT_WIDTH-1:0]    count_q, count_d;
    logic [FRAME_WIDTH-1:0]  frame_q, frame_d;
    logic                    oneshot_q, oneshot_d;
    logic                    load_lag, step_lag;
    logic                    ack_expired;

`ifdef INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    assign ack_expired = (state_q == WAIT_ACK) && (wd_q == ACK_TIMEOUT_LIMIT - 16'd1);

    always_comb begin
        wd_d      = (state_q == WAIT_ACK) ? wd_q + 16'd1 : 16'd0;
        timeout_d = timeout_q;
        if ((state_q != IDLE) && (state_d == IDLE) && !enable) begin
            timeout_d = 1'b0;
        end else if (ack_expired && !capture_ack) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge smpclk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign ack_timeout = timeout_q;
`else
    assign ack_expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        frame_d        = frame_q;
        oneshot_d      = oneshot_q;
        counters_reset = 1'b1;
        capture        = 1'b0;
        load_lag       = 1'b0;
        step_lag       = 1'b0;
        busy           = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                load_lag = 1'b1;
                if (enable && (integrate || strobe)) begin
                    state_d   = CLEAR;
                    oneshot_d = !integrate;
                end
            end
            CLEAR: begin
                count_d = (int_cycles == '0) ? INT_WIDTH'(1) : int_cycles;
                state_d = INTEGRATE;
            end
            INTEGRATE: begin
                counters_reset = 1'b0;
                count_d        = count_q - INT_WIDTH'(1);
                if (count_q == INT_WIDTH'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                counters_reset = 1'b0;
                capture        = 1'b1;
                state_d        = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (capture_ack || ack_expired) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                step_lag = 1'b1;
                frame_d  = frame_q + FRAME_WIDTH'(1);
                if (enable && integrate && !oneshot_q) begin
                    state_d = CLEAR;
                end else begin
                    state_d   = IDLE;
                    oneshot_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort: a capture already on the output stands, but the frame is not counted.
        if (!enable && (state_q != IDLE)) begin
            state_d   = IDLE;
            frame_d   = frame_q;
            oneshot_d = 1'b0;
            step_lag  = 1'b0;
        end
    end

    always_ff @(posedge smpclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            frame_q   <= '0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            frame_q   <= frame_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign frame_count = frame_q;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_line
        lag_stepper #(
            .LAG_WIDTH (LAG_WIDTH),
            .LIMIT     (MAX_LAG_AUTO)
        ) u_auto (
            .smpclk  (smpclk),
            .reset_n (reset_n),
            .base    (auto_base[i*LAG_WIDTH +: LAG_WIDTH]),
            .scan    (scan_auto[i]),
            .step    (step_lag),
            .load    (load_lag),
            .lag     (auto_lag[i*LAG_WIDTH +: LAG_WIDTH])
        );

        lag_stepper #(
            .LAG_WIDTH (LAG_WIDTH),
            .LIMIT     (MAX_LAG_CROSS)
        ) u_cross (
            .smpclk  (smpclk),
            .reset_n (reset_n),
            .base    (cross_base[i*LAG_WIDTH +: LAG_WIDTH]),
            .scan    (scan_cross[i]),
            .step    (step_lag),
            .load    (load_lag),
            .lag     (cross_lag[i*LAG_WIDTH +: LAG_WIDTH])
        );
    end

endmodule

// File: tb/tb_integration_scheduler.sv
// Directed bench for integration_scheduler with hand-computed frame timing.
module tb_integration_scheduler;

    localparam int unsigned NI = 8;
    localparam int unsigned LW = 12;
    localparam int unsigned IW = 32;
    localparam int unsigned FW = 16;

    logic            smpclk;
    logic            reset_n;
    logic            enable;
    logic            integrate;
    logic            strobe;
    logic [IW-1:0]   int_cycles;
    logic [NI-1:0]   scan_auto;
    logic [NI-1:0]   scan_cross;
    logic [NI*LW-1:0] auto_base;
    logic [NI*LW-1:0] cross_base;
    logic            capture_ack;
    logic            counters_reset;
    logic            capture;
    logic [NI*LW-1:0] auto_lag;
    logic [NI*LW-1:0] cross_lag;
    logic            busy;
    logic [FW-1:0]   frame_count;
`ifdef INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN
    logic            ack_timeout;
`endif

    int tests = 0;
    int fails = 0;

    integration_scheduler #(
        .NUM_INPUTS    (NI),
        .LAG_WIDTH     (LW),
        .MAX_LAG_AUTO  (4),
        .MAX_LAG_CROSS (2),
        .INT_WIDTH     (IW),
        .FRAME_WIDTH   (FW)
    ) dut (
        .smpclk         (smpclk),
        .reset_n        (reset_n),
        .enable         (enable),
        .integrate      (integrate),
        .strobe         (strobe),
        .int_cycles     (int_cycles),
        .scan_auto      (scan_auto),
        .scan_cross     (scan_cross),
        .auto_base      (auto_base),
        .cross_base     (cross_base),
        .capture_ack    (capture_ack),
        .counters_reset (counters_reset),
        .capture        (capture),
        .auto_lag       (auto_lag),
        .cross_lag      (cross_lag),
        .busy           (busy),
`ifdef INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN
        .ack_timeout    (ack_timeout),
`endif
        .frame_count    (frame_count)
    );

    initial begin
        smpclk = 1'b0;
        forever #5 smpclk = ~smpclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one frame; act as the packet generator, acking 3 cycles after capture.
    task automatic run_strobe_frame(input int ic, input int exp_frame, input string tag);
        int low_cnt = 0;
        int cap_cnt = 0;
        int cap_n   = 0;
        int eff     = (ic == 0) ? 1 : ic;
        int_cycles  = ic;
        @(negedge smpclk);
        strobe = 1'b1;
        @(posedge smpclk);
        #1 strobe = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge smpclk);
            if (!counters_reset) low_cnt++;
            if (capture) begin
                cap_cnt++;
                if (cap_n == 0) cap_n = n;
            end
            if (cap_n > 0 && n == cap_n + 3) capture_ack = 1'b1;
            if (cap_n > 0 && n == cap_n + 4) capture_ack = 1'b0;
        end
        check({tag, "_rst_low_cycles"}, 64'(low_cnt), 64'(eff + 1));
        check({tag, "_capture_count"}, 64'(cap_cnt), 64'd1);
        check({tag, "_capture_cycle"}, 64'(cap_n), 64'(eff + 2));
        check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_frame));
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int exp_auto [5] = '{1, 2, 3, 1, 2};
        int caps;
        reset_n     = 1'b0;
        enable      = 1'b1;
        integrate   = 1'b0;
        strobe      = 1'b0;
        int_cycles  = '0;
        scan_auto   = '0;
        scan_cross  = '0;
        auto_base   = '0;
        cross_base  = '0;
        capture_ack = 1'b0;
        auto_base[0 +: LW]  = 12'd1;
        auto_base[LW +: LW] = 12'd5;
        cross_base[0 +: LW] = 12'd7;

        // Reset values while held in reset
        #12;
        check("reset_counters_reset", 64'(counters_reset), 64'd1);
        check("reset_capture", 64'(capture), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame", 64'(frame_count), 64'd0);
        check("reset_auto_lag", 64'(auto_lag[0 +: LW]), 64'd0);
        check("reset_cross_lag", 64'(cross_lag[0 +: LW]), 64'd0);

        @(negedge smpclk);
        reset_n = 1'b1;
        @(negedge smpclk);
        check("idle_loads_auto0", 64'(auto_lag[0 +: LW]), 64'd1);
        check("idle_loads_auto1", 64'(auto_lag[LW +: LW]), 64'd5);
        check("idle_loads_cross0", 64'(cross_lag[0 +: LW]), 64'd7);

        // Strobe, int_cycles=10
        run_strobe_frame(10, 1, "strobe10");

        // Continuous, int_cycles=0, ack tied high: 5-cycle frames
        capture_ack = 1'b1;
        int_cycles  = '0;
        @(negedge smpclk);
        integrate = 1'b1;
        @(posedge smpclk);
        for (int n = 1; n <= 15; n++) begin
            @(negedge smpclk);
            check($sformatf("cont_capture_n%0d", n), 64'(capture), 64'((n % 5) == 3));
            check($sformatf("cont_crst_n%0d", n), 64'(counters_reset),
                  64'(!((n % 5) == 2 || (n % 5) == 3)));
            check($sformatf("cont_frame_n%0d", n), 64'(frame_count), 64'(1 + (n - 1) / 5));
            if (n == 14) integrate = 1'b0;
        end
        @(negedge smpclk);
        @(negedge smpclk);
        check("cont_idle_after", 64'(busy), 64'd0);
        check("cont_frame_final", 64'(frame_count), 64'd4);

        // Lag scan: line 0 auto 1,2,3,1,2; line 0 cross unscanned; line 2 cross 0,1,0,1,0
        scan_auto   = 8'b0000_0001;
        scan_cross  = 8'b0000_0100;
        int_cycles  = 2;
        caps        = 0;
        @(negedge smpclk);
        integrate = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge smpclk);
            if (capture && caps < 5) begin
                check($sformatf("scan_auto0_f%0d", caps), 64'(auto_lag[0 +: LW]),
                      64'(exp_auto[caps]));
                check($sformatf("scan_auto1_f%0d", caps), 64'(auto_lag[LW +: LW]), 64'd5);
                check($sformatf("scan_cross0_f%0d", caps), 64'(cross_lag[0 +: LW]), 64'd7);
                check($sformatf("scan_cross2_f%0d", caps), 64'(cross_lag[2*LW +: LW]),
                      64'(caps % 2));
                caps++;
                if (caps == 5) integrate = 1'b0;
            end
        end
        check("scan_frames", 64'(caps), 64'd5);
        check("scan_frame_count", 64'(frame_count), 64'd9);
        check("scan_idle", 64'(busy), 64'd0);
        check("scan_reload_base", 64'(auto_lag[0 +: LW]), 64'd1);
        capture_ack = 1'b0;
        scan_auto   = '0;
        scan_cross  = '0;

        // Enable dropped mid-INTEGRATE
        int_cycles = 10;
        @(negedge smpclk);
        strobe = 1'b1;
        @(posedge smpclk);
        #1 strobe = 1'b0;
        repeat (4) @(negedge smpclk);
        check("abort_in_integrate", 64'(counters_reset), 64'd0);
        enable = 1'b0;
        @(negedge smpclk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_crst", 64'(counters_reset), 64'd1);
        caps = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge smpclk);
            if (capture) caps++;
        end
        check("abort_no_capture", 64'(caps), 64'd0);
        check("abort_frame", 64'(frame_count), 64'd9);
        enable = 1'b1;

        // Asynchronous reset while in WAIT_ACK
        int_cycles = 1;
        @(negedge smpclk);
        strobe = 1'b1;
        @(posedge smpclk);
        #1 strobe = 1'b0;
        repeat (5) @(negedge smpclk);
        check("wait_ack_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_crst", 64'(counters_reset), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_capture", 64'(capture), 64'd0);
        check("arst_frame", 64'(frame_count), 64'd0);
        check("arst_auto_lag", 64'(auto_lag[0 +: LW]), 64'd0);
        #2 reset_n = 1'b1;
        run_strobe_frame(3, 1, "post_reset");

`ifdef INTEGRATION_SCHEDULER_ACK_TIMEOUT_EN
        // Watchdog: ack never asserted
        caps = 0;
        int_cycles = 1;
        @(negedge smpclk);
        strobe = 1'b1;
        @(posedge smpclk);
        #1 strobe = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge smpclk);
            if (!busy) break;
            caps++;
        end
        check("timeout_busy_cycles", 64'(caps), 64'd65539);
        check("timeout_flag", 64'(ack_timeout), 64'd1);
        check("timeout_frame", 64'(frame_count), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
